// File: rtl/lsu_mem_if.sv
// Request/response bundle between a core's load/store unit and lsu_mem.
interface lsu_mem_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/lsu_mem.sv
// Byte/halfword/word data memory with fixed access latency and fault reporting.
// Accesses commit at the accepting edge; the response is released LATENCY cycles later.
module lsu_mem #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset,
  lsu_mem_if.slave bus
);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_pend_err;
  logic [31:0] r_pend_data;

  logic          w_accept;
  logic          w_range_err;
  logic          w_size_err;
  logic          w_fault;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [15:0]   w_shift;
  logic [31:0]   w_load;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wmask;

  assign w_accept    = (r_state == S_IDLE) && bus.req;
  assign w_idx       = bus.addr[IW+1:2];
  assign w_range_err = {2'b00, bus.addr[31:2]} >= DEPTH;
  assign w_word      = w_range_err ? '0 : mem[w_idx];
  assign w_shift     = 16'(w_word >> {bus.addr[1:0], 3'b000});

  always_comb begin
    w_size_err = 1'b1;
    case (bus.funct3)
      3'b000, 3'b100: w_size_err = bus.we & bus.funct3[2];
      3'b001, 3'b101: w_size_err = bus.addr[0] | (bus.we & bus.funct3[2]);
      3'b010:         w_size_err = |bus.addr[1:0];
      default:        w_size_err = 1'b1;
    endcase
    w_fault = w_range_err | w_size_err;
  end

  // Extended at accept; equivalent to extending the captured word later.
  always_comb begin
    w_load = '0;
    if (!bus.we && !w_fault) begin
      case (bus.funct3)
        3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
        3'b100:  w_load = {24'h0, w_shift[7:0]};
        3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
        3'b101:  w_load = {16'h0, w_shift[15:0]};
        3'b010:  w_load = w_word;
        default: w_load = '0;
      endcase
    end
  end

  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << bus.addr[1:0];
        w_wdata = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = 4'b0011 << {bus.addr[1], 1'b0};
        w_wdata = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_accept && bus.we && !w_fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wmask[i]) mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_pend_err  <= 1'b0;
      r_pend_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_busy <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_rdata <= w_load;
              r_err   <= w_fault;
            end else begin
              r_state     <= S_WAIT;
              r_cnt       <= 4'(LATENCY - 1);
              r_pend_data <= w_load;
              r_pend_err  <= w_fault;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_rdata <= r_pend_data;
            r_err   <= r_pend_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: three instances (LATENCY 1, 4, 8) share one stimulus port selected by sel.
module tb_lsu_mem;
  localparam int unsigned DEPTH = 512;

  logic clk;
  logic reset;
  int   sel;
  logic req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic busy, ready, err;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [3][DEPTH];
  int lat_of [3] = '{1, 4, 8};

  lsu_mem_if bus0 ();
  lsu_mem_if bus1 ();
  lsu_mem_if bus2 ();

  lsu_mem #(.DEPTH(DEPTH), .LATENCY(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  lsu_mem #(.DEPTH(DEPTH), .LATENCY(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  lsu_mem #(.DEPTH(DEPTH), .LATENCY(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus0.req = req && (sel == 0);
  assign bus1.req = req && (sel == 1);
  assign bus2.req = req && (sel == 2);
  assign bus0.we = we;  assign bus0.funct3 = f3; assign bus0.addr = addr; assign bus0.wdata = wdata;
  assign bus1.we = we;  assign bus1.funct3 = f3; assign bus1.addr = addr; assign bus1.wdata = wdata;
  assign bus2.we = we;  assign bus2.funct3 = f3; assign bus2.addr = addr; assign bus2.wdata = wdata;

  always_comb begin
    busy = bus0.busy; ready = bus0.ready; rdata = bus0.rdata; err = bus0.err;
    if (sel == 1) begin
      busy = bus1.busy; ready = bus1.ready; rdata = bus1.rdata; err = bus1.err;
    end else if (sel == 2) begin
      busy = bus2.busy; ready = bus2.ready; rdata = bus2.rdata; err = bus2.err;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode size from funct3, check alignment/range arithmetically, move bytes.
  task automatic model_op(input int s, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e);
    int unsigned size, idx, off;
    logic [31:0] v;
    idx = a >> 2;
    off = a % 4;
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (w && f[2]) size = 0;
    e  = (size == 0) || (idx >= DEPTH);
    if (!e) e = (a % size) != 0;
    rd = '0;
    if (!e) begin
      if (w) begin
        for (int unsigned b = 0; b < size; b++)
          ref_mem[s][idx][8*(off+b) +: 8] = wd[8*b +: 8];
      end else begin
        v = '0;
        for (int unsigned b = 0; b < size; b++)
          v = v | (32'(ref_mem[s][idx][8*(off+b) +: 8]) << (8*b));
        if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endtask

  // One access on the selected instance; returns response, latency and whether the pulse ended cleanly.
  task automatic access(input int s, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat,
                        output time t_acc, output logic clean);
    int g;
    sel = s;
    g = 0;
    @(negedge clk);
    while (busy && g < 40) begin
      @(negedge clk);
      g++;
    end
    we = w; f3 = f; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk);
    t_acc = $time;
    #1;
    req = 1'b0;
    lat = 1;
    while (!ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rdata;
    e  = err;
    @(posedge clk);
    #1;
    clean = !ready && !busy && (rdata == 32'h0) && !err;
  endtask

  task automatic checked_op(input string name, input int s, input logic w, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, exp_rd;
    logic e, exp_e, clean;
    int lat;
    time t;
    model_op(s, w, f, a, wd, exp_rd, exp_e);
    access(s, w, f, a, wd, rd, e, lat, t, clean);
    tests++;
    if (rd !== exp_rd || e !== exp_e) begin
      fails++;
      $display("FAIL %s: got rdata=%h err=%b want rdata=%h err=%b (f3=%0d addr=%h)",
               name, rd, e, exp_rd, exp_e, f, a);
    end
    tests++;
    if (lat !== lat_of[s] || clean !== 1'b1) begin
      fails++;
      $display("FAIL %s_timing: got lat=%0d clean=%b want lat=%0d clean=1", name, lat, clean, lat_of[s]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      tests++;
      if ({busy, ready, err} !== 3'b000 || rdata !== 32'h0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got busy=%b ready=%b err=%b rdata=%h want all 0",
                 i, busy, ready, err, rdata);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word;
    logic [31:0] rd;
    logic e, clean;
    int lat;
    time t1, t2;
    checked_op("sw_64", 0, 1'b1, 3'b010, 32'h64, 32'hDEADBEEF);
    access(0, 1'b0, 3'b010, 32'h64, 32'h0, rd, e, lat, t1, clean);
    tests++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== 1) begin
      fails++;
      $display("FAIL lw_64: got rdata=%h err=%b lat=%0d want DEADBEEF 0 1", rd, e, lat);
    end
    access(0, 1'b0, 3'b010, 32'h64, 32'h0, rd, e, lat, t2, clean);
    tests++;
    if (t2 - t1 !== 20) begin
      fails++;
      $display("FAIL back_to_back: got spacing=%0t want 20", t2 - t1);
    end
  endtask

  task automatic test_subword;
    logic [31:0] rd;
    logic e, clean;
    int lat;
    time t;
    logic [31:0] exp_v [6] = '{32'h1122AA44, 32'h8001AA44, 32'hFFFFFFAA,
                               32'h000000AA, 32'hFFFF8001, 32'h00008001};
    logic [2:0]  op_f  [6] = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] op_a  [6] = '{32'h60, 32'h60, 32'h61, 32'h61, 32'h62, 32'h62};
    checked_op("sw_60", 0, 1'b1, 3'b010, 32'h60, 32'h11223344);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) checked_op("sb_61", 0, 1'b1, 3'b000, 32'h61, 32'h000000AA);
      if (i == 1) checked_op("sh_62", 0, 1'b1, 3'b001, 32'h62, 32'h00008001);
      access(0, 1'b0, op_f[i], op_a[i], 32'h0, rd, e, lat, t, clean);
      tests++;
      if (rd !== exp_v[i] || e !== 1'b0) begin
        fails++;
        $display("FAIL subword[%0d]: got rdata=%h err=%b want %h 0", i, rd, e, exp_v[i]);
      end
    end
  endtask

  task automatic test_faults;
    checked_op("lw_66",      0, 1'b0, 3'b010, 32'h66, 32'h0);
    checked_op("sh_63",      0, 1'b1, 3'b001, 32'h63, 32'h5555);
    checked_op("sw_oob",     0, 1'b1, 3'b010, DEPTH * 4, 32'h12345678);
    checked_op("lw_f011",    0, 1'b0, 3'b011, 32'h64, 32'h0);
    checked_op("st_f100",    0, 1'b1, 3'b100, 32'h60, 32'hFFFFFFFF);
    checked_op("sw_61",      0, 1'b1, 3'b010, 32'h61, 32'hFFFFFFFF);
    checked_op("keep_60",    0, 1'b0, 3'b010, 32'h60, 32'h0);
    checked_op("keep_64",    0, 1'b0, 3'b010, 32'h64, 32'h0);
  endtask

  task automatic test_random(input int s, input int n);
    logic [2:0]  f;
    logic [31:0] a;
    for (int unsigned wi = 0; wi < 16; wi++)
      checked_op("init", s, 1'b1, 3'b010, wi * 4, $urandom);
    for (int i = 0; i < n; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      checked_op("random", s, 1'($urandom_range(0, 1)), f, a, $urandom);
    end
  endtask

  task automatic test_latency4;
    logic [31:0] exp0, exp1;
    logic e0, e1;
    int g;
    model_op(1, 1'b0, 3'b010, 32'h0, 32'h0, exp0, e0);
    model_op(1, 1'b0, 3'b010, 32'h4, 32'h0, exp1, e1);
    sel = 1;
    @(negedge clk);
    we = 1'b0; f3 = 3'b010; addr = 32'h0; req = 1'b1;
    @(posedge clk);
    #1;
    addr = 32'h4;
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if (busy !== 1'b1 || ready !== (c == 4)) begin
        fails++;
        $display("FAIL lat4_cycle%0d: got busy=%b ready=%b want busy=1 ready=%b", c, busy, ready, c == 4);
      end
      if (c == 4) begin
        tests++;
        if (rdata !== exp0 || err !== e0) begin
          fails++;
          $display("FAIL lat4_data: got %h/%b want %h/%b", rdata, err, exp0, e0);
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL lat4_no_accept_in_resp: got busy=%b ready=%b want 0 0", busy, ready);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL lat4_reaccept: got busy=%b want 1", busy);
    end
    g = 1;
    while (!ready && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    tests++;
    if (g !== 4 || rdata !== exp1 || err !== e1) begin
      fails++;
      $display("FAIL lat4_second: got lat=%0d rdata=%h err=%b want 4 %h %b", g, rdata, err, exp1, e1);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic e, clean;
    int lat, seen;
    time t;
    checked_op("sw_l8", 2, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    sel = 2;
    @(negedge clk);
    we = 1'b0; f3 = 3'b010; addr = 32'h10; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({busy, ready, err} !== 3'b000 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got busy=%b ready=%b err=%b rdata=%h want 0", busy, ready, err, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ready || busy) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_mid_discard: got %0d active cycles want 0", seen);
    end
    access(2, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, t, clean);
    tests++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0 || lat !== 8) begin
      fails++;
      $display("FAIL reset_mid_store_kept: got %h/%b lat=%0d want CAFEF00D/0 8", rd, e, lat);
    end
    @(negedge clk);
    reset = 1'b1;
    we = 1'b0; f3 = 3'b010; addr = 32'h10; req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL accept_after_reset: got busy=%b want 1", busy);
    end
    lat = 1;
    while (!ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat !== 8 || rdata !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL accept_after_reset_data: got lat=%0d rdata=%h want 8 CAFEF00D", lat, rdata);
    end
  endtask

  initial begin
    sel = 0; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_random(0, 80);
    test_random(1, 40);
    test_latency4();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
